cfu_bridge: RTL and testbench

- Sits between the CPU execute stage and the CFU datapath.
- Converts the CPU's stall-based custom-instruction interface into a registered valid/ready request channel and a valid/ready response channel.
- Freezes the pipeline while a CFU operation is in flight, then returns the result to the CPU.
- Allows multi-cycle, variable-latency CFU datapaths without exposing pipeline timing to them.

---
 rtl/cfu_bridge_if.sv | 47 ++++
 rtl/cfu_bridge.sv | 192 +++++++++++++++++++
 tb/tb_cfu_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_bridge_if.sv
// cfu_bridge_if: bundles the CPU execute-stage signals and the CFU datapath
// request/response channels seen by cfu_bridge.
//   slave  : bridge side (takes CPU/datapath inputs, drives stall, result,
//            request payload, response ready, latency and error)
//   master : environment side (CPU pipeline plus CFU datapath)
interface cfu_bridge_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 11,
  parameter int unsigned CNT_W  = 16
);
  // CPU execute stage
  logic              stall_i;
  logic              valid_i;
  logic [CTRL_W-1:0] cfu_ctrl_i;
  logic [XLEN-1:0]   src1_i;
  logic [XLEN-1:0]   src2_i;
  logic              stall_o;
  logic [XLEN-1:0]   rslt_o;
  // Request channel to the CFU datapath
  logic              req_valid_o;
  logic              req_ready_i;
  logic [2:0]        req_funct3_o;
  logic [6:0]        req_funct7_o;
  logic [XLEN-1:0]   req_src1_o;
  logic [XLEN-1:0]   req_src2_o;
  // Response channel from the CFU datapath
  logic              rsp_valid_i;
  logic              rsp_ready_o;
  logic [XLEN-1:0]   rsp_data_i;
  // Status
  logic [CNT_W-1:0]  lat_cnt_o;
  logic              err_o;

  modport slave (
    input  stall_i, valid_i, cfu_ctrl_i, src1_i, src2_i,
    input  req_ready_i, rsp_valid_i, rsp_data_i,
    output stall_o, rslt_o, req_valid_o, req_funct3_o, req_funct7_o,
    output req_src1_o, req_src2_o, rsp_ready_o, lat_cnt_o, err_o
  );

  modport master (
    output stall_i, valid_i, cfu_ctrl_i, src1_i, src2_i,
    output req_ready_i, rsp_valid_i, rsp_data_i,
    input  stall_o, rslt_o, req_valid_o, req_funct3_o, req_funct7_o,
    input  req_src1_o, req_src2_o, rsp_ready_o, lat_cnt_o, err_o
  );
endinterface

// File: rtl/cfu_bridge.sv
// cfu_bridge: turns the CPU's stall-based custom-instruction interface into a
// valid/ready request channel and a valid/ready response channel towards a
// variable-latency CFU datapath, freezing the pipeline while an op is in flight.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   bus    - cfu_bridge_if.slave: CPU side (stall/valid/ctrl/operands in,
//            stall_o/rslt_o out), request channel (req_*), response channel
//            (rsp_*), lat_cnt_o (latency of last completed op), err_o.
// Optional feature: define CFU_BRIDGE_TIMEOUT_EN to add a watchdog that aborts
// an op after TIMEOUT_CYC cycles in REQ+WAIT with result 32'hDEAD_BEEF and a
// sticky err_o. Without it the bridge waits forever and err_o is tied low.
module cfu_bridge #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 11,
  parameter int unsigned CNT_W  = 16
`ifdef CFU_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
  input logic          clk_i,
  input logic          rst_ni,
  cfu_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q;
  logic [XLEN-1:0]   rslt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  lat_q;
  logic [CTRL_W-1:0] ctrl;
  logic              start_c;
  logic              busy;
  logic              ld_req;
  logic              ld_rsp;

  assign ctrl = bus.cfu_ctrl_i;
  assign busy = (state_q == REQ) || (state_q == WAIT);

  // Gated by rst_ni so stall_o drops immediately while reset is held.
  assign start_c = rst_ni && (state_q == IDLE) && bus.valid_i && ctrl[0];

  // Running latency counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef CFU_BRIDGE_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] wd_q;
  logic            wd_hit;
  logic            tmo;
  logic            err_q;

  // Current REQ/WAIT cycle is the TIMEOUT_CYC-th one.
  assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (ld_req) begin
        wd_q <= '0;
      end else if (busy) begin
        wd_q <= wd_q + WD_W'(1);
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and load strobes.
  always_comb begin
    state_d = state_q;
    ld_req  = 1'b0;
    ld_rsp  = 1'b0;
`ifdef CFU_BRIDGE_TIMEOUT_EN
    tmo     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = REQ;
          ld_req  = 1'b1;
        end
      end
      REQ: begin
`ifdef CFU_BRIDGE_TIMEOUT_EN
        if (wd_hit) begin
          state_d = DONE;
          tmo     = 1'b1;
        end else
`endif
        if (bus.req_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response in the limit cycle beats the watchdog.
        if (bus.rsp_valid_i) begin
          state_d = DONE;
          ld_rsp  = 1'b1;
        end
`ifdef CFU_BRIDGE_TIMEOUT_EN
        else if (wd_hit) begin
          state_d = DONE;
          tmo     = 1'b1;
        end
`endif
      end
      DONE: begin
        if (!bus.stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request payload, running counter, result and recorded latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= '0;
      cnt_q  <= '0;
      lat_q  <= '0;
      rslt_q <= '0;
    end else begin
      if (ld_req) begin
        req_q.funct7 <= ctrl[10:4];
        req_q.funct3 <= ctrl[3:1];
        req_q.src1   <= bus.src1_i;
        req_q.src2   <= bus.src2_i;
        cnt_q        <= '0;
      end else if (busy) begin
        cnt_q <= cnt_inc;
      end
      // Recorded latency includes the acceptance cycle itself.
      if (ld_rsp) begin
        rslt_q <= bus.rsp_data_i;
        lat_q  <= cnt_inc;
      end
`ifdef CFU_BRIDGE_TIMEOUT_EN
      else if (tmo) begin
        rslt_q <= XLEN'(32'hDEAD_BEEF);
      end
`endif
    end
  end

  assign bus.stall_o      = start_c || busy;
  assign bus.rslt_o       = (state_q == DONE) ? rslt_q : '0;
  assign bus.req_valid_o  = (state_q == REQ);
  assign bus.rsp_ready_o  = (state_q == WAIT);
  assign bus.req_funct3_o = req_q.funct3;
  assign bus.req_funct7_o = req_q.funct7;
  assign bus.req_src1_o   = req_q.src1;
  assign bus.req_src2_o   = req_q.src2;
  assign bus.lat_cnt_o    = lat_q;

endmodule

// File: tb/tb_cfu_bridge.sv
// tb_cfu_bridge: directed and randomized checks of cfu_bridge against a
// transaction-level model (per-op phase lengths and expected results).
module tb_cfu_bridge;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 11;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cfu_bridge_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  cfu_bridge #(
    .XLEN(XLEN),
    .CTRL_W(CTRL_W),
    .CNT_W(CNT_W)
`ifdef CFU_BRIDGE_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [CNT_W-1:0] exp_lat = '0;
  logic             exp_err = 1'b0;
  logic [2:0]       exp_f3  = '0;
  logic [6:0]       exp_f7  = '0;
  logic [XLEN-1:0]  exp_s1  = '0;
  logic [XLEN-1:0]  exp_s2  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic chk_cycle(input string ph, input logic e_stall, input logic e_rv,
                           input logic e_rr, input logic [XLEN-1:0] e_rslt);
    chk({ph, ".stall_o"},     64'(bus.stall_o),      64'(e_stall));
    chk({ph, ".req_valid_o"}, 64'(bus.req_valid_o),  64'(e_rv));
    chk({ph, ".rsp_ready_o"}, 64'(bus.rsp_ready_o),  64'(e_rr));
    chk({ph, ".rslt_o"},      64'(bus.rslt_o),       64'(e_rslt));
    chk({ph, ".lat_cnt_o"},   64'(bus.lat_cnt_o),    64'(exp_lat));
    chk({ph, ".err_o"},       64'(bus.err_o),        64'(exp_err));
    chk({ph, ".funct3"},      64'(bus.req_funct3_o), 64'(exp_f3));
    chk({ph, ".funct7"},      64'(bus.req_funct7_o), 64'(exp_f7));
    chk({ph, ".src1"},        64'(bus.req_src1_o),   64'(exp_s1));
    chk({ph, ".src2"},        64'(bus.req_src2_o),   64'(exp_s2));
  endtask

  // Randomize every input; callers then pin the ones that matter this cycle.
  task automatic noise();
    bus.stall_i     = 1'($urandom_range(0, 1));
    bus.valid_i     = 1'($urandom_range(0, 1));
    bus.cfu_ctrl_i  = CTRL_W'($urandom);
    bus.src1_i      = XLEN'($urandom);
    bus.src2_i      = XLEN'($urandom);
    bus.req_ready_i = 1'($urandom_range(0, 1));
    bus.rsp_valid_i = 1'($urandom_range(0, 1));
    bus.rsp_data_i  = XLEN'($urandom);
  endtask

  // One op: gap idle cycles, start, r ready-low REQ cycles, response in the
  // (w+1)-th WAIT cycle, then s stalled DONE cycles plus one release cycle.
  task automatic run_op(input int gap, input int r, input int w, input int s,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [XLEN-1:0] res);
    int l;
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      noise();
      bus.cfu_ctrl_i[0] = 1'b0;
      #1 chk_cycle("idle", 1'b0, 1'b0, 1'b0, '0);
    end
    @(negedge clk);
    noise();
    bus.valid_i    = 1'b1;
    bus.cfu_ctrl_i = {f7, f3, 1'b1};
    bus.src1_i     = a;
    bus.src2_i     = b;
    #1 chk_cycle("start", 1'b1, 1'b0, 1'b0, '0);
    exp_f3 = f3;
    exp_f7 = f7;
    exp_s1 = a;
    exp_s2 = b;
    for (int k = 0; k <= r; k++) begin
      @(negedge clk);
      noise();
      bus.req_ready_i = (k == r);
      #1 chk_cycle("req", 1'b1, 1'b1, 1'b0, '0);
    end
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      noise();
      bus.rsp_valid_i = (k == w);
      if (k == w) bus.rsp_data_i = res;
      #1 chk_cycle("wait", 1'b1, 1'b0, 1'b1, '0);
    end
    l = r + w + 2;
    exp_lat = (l > int'({CNT_W{1'b1}})) ? '1 : CNT_W'(l);
    for (int k = 0; k <= s; k++) begin
      @(negedge clk);
      noise();
      bus.stall_i = (k < s);
      #1 chk_cycle("done", 1'b0, 1'b0, 1'b0, res);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.stall_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.cfu_ctrl_i  = '0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_data_i  = '0;

    @(negedge clk);
    #1 chk_cycle("reset", 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic op: 5+7 -> 12, response 3 cycles after acceptance.
    run_op(1, 0, 2, 0, 32'd5, 32'd7, 3'd0, 7'd1, 32'd12);
    // Ready held low 10 cycles.
    run_op(2, 10, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 7'h2A, 32'h0BAD_F00D);
    // Stall in DONE for 3 cycles.
    run_op(0, 0, 0, 3, 32'h11, 32'h22, 3'd7, 7'h7F, 32'h0000_ABCD);

    // Non-CFU instruction with a stray response pulse.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      noise();
      bus.valid_i        = 1'b1;
      bus.cfu_ctrl_i[0]  = 1'b0;
      bus.rsp_valid_i    = 1'b1;
      #1 chk_cycle("noncfu", 1'b0, 1'b0, 1'b0, '0);
    end

    // Randomized ops, including back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             XLEN'($urandom), XLEN'($urandom), 3'($urandom), 7'($urandom),
             XLEN'($urandom));
    end

`ifdef CFU_BRIDGE_TIMEOUT_EN
    // Watchdog: accepted but never answered; 8 busy cycles then abort.
    @(negedge clk);
    noise();
    bus.valid_i    = 1'b1;
    bus.cfu_ctrl_i = {7'h55, 3'd3, 1'b1};
    bus.src1_i     = 32'hA;
    bus.src2_i     = 32'hB;
    #1 chk_cycle("tmo_start", 1'b1, 1'b0, 1'b0, '0);
    exp_f3 = 3'd3;
    exp_f7 = 7'h55;
    exp_s1 = 32'hA;
    exp_s2 = 32'hB;
    @(negedge clk);
    noise();
    bus.req_ready_i = 1'b1;
    #1 chk_cycle("tmo_req", 1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      noise();
      bus.rsp_valid_i = 1'b0;
      #1 chk_cycle("tmo_wait", 1'b1, 1'b0, 1'b1, '0);
    end
    exp_err = 1'b1;
    @(negedge clk);
    noise();
    bus.stall_i     = 1'b0;
    bus.rsp_valid_i = 1'b1;
    #1 chk_cycle("tmo_done", 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      noise();
      bus.cfu_ctrl_i[0] = 1'b0;
      bus.rsp_valid_i   = 1'b1;
      #1 chk_cycle("tmo_after", 1'b0, 1'b0, 1'b0, '0);
    end
    run_op(0, 1, 1, 0, 32'h3, 32'h4, 3'd1, 7'd2, 32'h77);
`endif

    // Reset in the middle of WAIT.
    @(negedge clk);
    noise();
    bus.valid_i    = 1'b1;
    bus.cfu_ctrl_i = {7'h03, 3'd2, 1'b1};
    bus.src1_i     = 32'hCAFE;
    bus.src2_i     = 32'hBEEF;
    #1 chk_cycle("rst_start", 1'b1, 1'b0, 1'b0, '0);
    exp_f3 = 3'd2;
    exp_f7 = 7'h03;
    exp_s1 = 32'hCAFE;
    exp_s2 = 32'hBEEF;
    @(negedge clk);
    noise();
    bus.req_ready_i = 1'b1;
    #1 chk_cycle("rst_req", 1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    noise();
    bus.rsp_valid_i = 1'b0;
    #1 chk_cycle("rst_wait", 1'b1, 1'b0, 1'b1, '0);
    @(negedge clk);
    noise();
    bus.rsp_valid_i   = 1'b0;
    bus.valid_i       = 1'b1;
    bus.cfu_ctrl_i[0] = 1'b1;
    rst_n = 1'b0;
    exp_lat = '0;
    exp_err = 1'b0;
    exp_f3  = '0;
    exp_f7  = '0;
    exp_s1  = '0;
    exp_s2  = '0;
    #1 chk_cycle("rst_held", 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      noise();
      bus.valid_i     = 1'b0;
      bus.rsp_valid_i = 1'b1;
      #1 chk_cycle("rst_after", 1'b0, 1'b0, 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
